projectile_scheduler: RTL and testbench
=======================================

Name: projectile_scheduler

Overview:
Owns a fixed pool of player projectile slots: beam bullets and missiles. Runs once per frame on frame_clk and converts fire-key presses into slot allocations. Enforces the fire cooldown and missile ammo, advances every live projectile, and retires projectiles that leave the screen, exhaust their range or are hit. Sits between keyboard decode and player position on one side, and the sprite renderer and collision logic on the other.

Parameters:
NUM_SLOTS, 4, projectile slots in the pool (2..8)
FIRE_KEY, 8'd13, keycode that fires a bullet
MISSILE_KEY, 8'd14, keycode that fires a missile
COOLDOWN, 4'd6, frames blocked after any successful shot
BULLET_STEP, 10'd8, bullet X pixels per frame
MISSILE_STEP, 10'd5, missile X pixels per frame
BULLET_RANGE, 6'd20, frames a bullet lives before expiring
MISSILE_MAX, 5'd10, ammo capacity and reset ammo
MUZZLE_OFS, 10'd8, spawn X offset from player_x toward facing
X_MIN, 10'd0, leftmost legal X
X_MAX, 10'd639, rightmost legal X

Ports:
frame_clk  in  1  frame clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-high reset
keycode  in  8  current keycode from keyboard decode
player_x  in  10  player X position
player_y  in  10  player Y position
facing  in  1  1 = right, 0 = left
ammo_add  in  1  pickup pulse; +1 missile, saturates at MISSILE_MAX
hit_clear  in  NUM_SLOTS  per-slot kill request from collision logic
slot_active  out  NUM_SLOTS  slot i is live
slot_kind  out  NUM_SLOTS  0 = bullet, 1 = missile
slot_x  out  10*NUM_SLOTS  packed X, slot i at [10i+9:10i]
slot_y  out  10*NUM_SLOTS  packed Y
ammo  out  5  missiles remaining
shot_fired  out  1  one-frame pulse, an allocation occurred
shot_dropped  out  1  one-frame pulse, press rejected (cooldown, no ammo or pool full)

Behaviour:
- Reset (async): all slots inactive; X/Y/kind/dir/range cleared to 0; key_prev=0; cooldown=0; ammo=MISSILE_MAX; pulses 0.
- Edge detect: fire_req = (keycode==FIRE_KEY) && (key_prev!=FIRE_KEY); same form for missile. key_prev <= keycode every frame. A held key fires exactly once.
- Accept condition: req && cooldown==0 && a free slot exists && (bullet || ammo>0). Otherwise shot_dropped=1 for that frame. Holding the key never re-triggers.
- Allocation: free mask = ~slot_active sampled at frame start; choose the lowest index.
- Slots retiring or cleared in the current frame are not free until the next frame.
- Spawn values: x = facing ? player_x+MUZZLE_OFS (clamped to X_MAX) : player_x-MUZZLE_OFS (clamped to X_MIN, no underflow); y = player_y; dir = facing; range = BULLET_RANGE.
- A spawned slot does not move on its spawn frame.
- Accepted shot: cooldown <= COOLDOWN; missile ammo decrements by 1.
- Cooldown decrements by 1 per frame, saturating at 0.
- Ammo: ammo_add and a missile fire in the same frame cancel (net 0). ammo_add at MISSILE_MAX is ignored.
- Per-slot update, priority order: hit_clear > retire > move.
  - Retire if any of:
    - dir=1 and x > X_MAX-step
    - dir=0 and x < X_MIN+step
    - bullet with range==1
  - Move: x ± step; bullets also decrement range. Y is constant.
- hit_clear on an inactive slot has no effect.
- All outputs are registered. Latency: key edge to slot_active = 1 frame_clk edge.

Decomposition:
- projectile_pkg: kind typedef (BULLET/MISSILE), slot struct {active, kind, dir, x, y, range}, default parameter constants.
- One sub-module, lowest_free_encoder: combinational; free mask in, index + valid out.

Test Plan:
- Reset, player_x=320, facing=1, keycode 0→13 held 10 frames → slot0 active at x=328, moves +8 per frame; shot_fired exactly once.
- Presses of key 13 on frames 0 and 3 → second press gives shot_dropped (cooldown). Press on frame 7 → slot1 allocated.
- Fill all 4 slots (presses spaced 7 frames apart), 5th press → shot_dropped; no slot overwritten.
- Bullet fired from x=100 facing right → expires after 20 frames (range), not at the screen edge.
- facing=0, player_x=4 → spawn x=0; retire on next frame. Missile from x=630 facing right → spawns at 638, retires on next frame.
- Missile fire with ammo=1 and ammo_add in the same frame → ammo stays 1. hit_clear[0] pulse → slot0 inactive next frame. A press in that same frame allocates slot1, not slot0.

Source files
------------

// File: rtl/projectile_pkg.sv
// Shared types and default constants for the projectile scheduler.
// Contents: projectile kind enum, per-slot state struct, and the default
// values for every tunable parameter of projectile_scheduler.
package projectile_pkg;

  typedef enum logic {
    BULLET  = 1'b0,
    MISSILE = 1'b1
  } kind_e;

  typedef struct packed {
    logic       active;
    kind_e      kind;
    logic       dir;     // 1 = travelling right
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] range;   // frames left for a bullet; unused by missiles
  } slot_t;

  localparam int         DEF_NUM_SLOTS    = 4;
  localparam logic [7:0] DEF_FIRE_KEY     = 8'd13;
  localparam logic [7:0] DEF_MISSILE_KEY  = 8'd14;
  localparam logic [3:0] DEF_COOLDOWN     = 4'd6;
  localparam logic [9:0] DEF_BULLET_STEP  = 10'd8;
  localparam logic [9:0] DEF_MISSILE_STEP = 10'd5;
  localparam logic [5:0] DEF_BULLET_RANGE = 6'd20;
  localparam logic [4:0] DEF_MISSILE_MAX  = 5'd10;
  localparam logic [9:0] DEF_MUZZLE_OFS   = 10'd8;
  localparam logic [9:0] DEF_X_MIN        = 10'd0;
  localparam logic [9:0] DEF_X_MAX        = 10'd639;

endpackage

// File: rtl/lowest_free_encoder.sv
// Combinational priority encoder: returns the lowest set bit of free_mask.
// Ports:
//   free_mask  in   N      1 = slot is free
//   idx        out  IDX_W  index of the lowest free slot (0 when none)
//   valid      out  1      at least one slot is free
module lowest_free_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     free_mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning downward lets the lowest free index be the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/projectile_scheduler.sv
// Projectile slot pool for the player: turns fire-key presses into slot
// allocations once per frame, enforces cooldown and missile ammo, moves live
// projectiles and retires them on screen exit, range expiry or hit.
// Ports:
//   frame_clk     in   1            frame clock, state updates on rising edge
//   Reset         in   1            asynchronous active-high reset
//   keycode       in   8            current keycode
//   player_x/y    in   10           player position
//   facing        in   1            1 = right, 0 = left
//   ammo_add      in   1            +1 missile pickup (saturating)
//   hit_clear     in   NUM_SLOTS    per-slot kill request
//   slot_active   out  NUM_SLOTS    slot live flags
//   slot_kind     out  NUM_SLOTS    0 = bullet, 1 = missile
//   slot_x/y      out  10*NUM_SLOTS packed positions, slot i at [10i+9:10i]
//   ammo          out  5            missiles remaining
//   shot_fired    out  1            pulse: allocation happened
//   shot_dropped  out  1            pulse: press rejected
module projectile_scheduler
  import projectile_pkg::*;
#(
  parameter int         NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter logic [7:0] FIRE_KEY     = DEF_FIRE_KEY,
  parameter logic [7:0] MISSILE_KEY  = DEF_MISSILE_KEY,
  parameter logic [3:0] COOLDOWN     = DEF_COOLDOWN,
  parameter logic [9:0] BULLET_STEP  = DEF_BULLET_STEP,
  parameter logic [9:0] MISSILE_STEP = DEF_MISSILE_STEP,
  parameter logic [5:0] BULLET_RANGE = DEF_BULLET_RANGE,
  parameter logic [4:0] MISSILE_MAX  = DEF_MISSILE_MAX,
  parameter logic [9:0] MUZZLE_OFS   = DEF_MUZZLE_OFS,
  parameter logic [9:0] X_MIN        = DEF_X_MIN,
  parameter logic [9:0] X_MAX        = DEF_X_MAX
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [9:0]              player_x,
  input  logic [9:0]              player_y,
  input  logic                    facing,
  input  logic                    ammo_add,
  input  logic [NUM_SLOTS-1:0]    hit_clear,
  output logic [NUM_SLOTS-1:0]    slot_active,
  output logic [NUM_SLOTS-1:0]    slot_kind,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [10*NUM_SLOTS-1:0] slot_y,
  output logic [4:0]              ammo,
  output logic                    shot_fired,
  output logic                    shot_dropped
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  slot_t            slot_q [NUM_SLOTS];
  slot_t            slot_d [NUM_SLOTS];
  logic [7:0]       key_prev;
  logic [3:0]       cooldown;

  logic             fire_req;
  logic             miss_req;
  logic             any_req;
  logic             accept;
  logic [NUM_SLOTS-1:0] free_mask;
  logic [IDX_W-1:0] alloc_idx;
  logic             free_valid;
  logic [10:0]      spawn_sum;
  logic [9:0]       spawn_x;

  function automatic logic [9:0] step_of(kind_e k);
    return (k == MISSILE) ? MISSILE_STEP : BULLET_STEP;
  endfunction

  // Bounds are compared in 11 bits so X_MAX-step / X_MIN+step never wrap.
  function automatic logic must_retire(slot_t s);
    logic [10:0] st;
    st = {1'b0, step_of(s.kind)};
    return (s.dir && (({1'b0, s.x} + st) > {1'b0, X_MAX})) ||
           (!s.dir && ({1'b0, s.x} < ({1'b0, X_MIN} + st))) ||
           (s.kind == BULLET && s.range == 6'd1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_mask[i] = ~slot_q[i].active;
    end
  end

  lowest_free_encoder #(
    .N     (NUM_SLOTS),
    .IDX_W (IDX_W)
  ) u_free_enc (
    .free_mask (free_mask),
    .idx       (alloc_idx),
    .valid     (free_valid)
  );

  always_comb begin
    fire_req = (keycode == FIRE_KEY) && (key_prev != FIRE_KEY);
    miss_req = (keycode == MISSILE_KEY) && (key_prev != MISSILE_KEY);
    any_req  = fire_req || miss_req;
    accept   = any_req && (cooldown == 4'd0) && free_valid &&
               (fire_req || (ammo != 5'd0));
  end

  always_comb begin
    spawn_sum = {1'b0, player_x} + {1'b0, MUZZLE_OFS};
    if (facing) begin
      spawn_x = (spawn_sum > {1'b0, X_MAX}) ? X_MAX : spawn_sum[9:0];
    end else begin
      spawn_x = ({1'b0, player_x} < ({1'b0, X_MIN} + {1'b0, MUZZLE_OFS})) ?
                X_MIN : (player_x - MUZZLE_OFS);
    end
  end

  // Kill beats retire beats move; a slot freed this frame only becomes
  // allocatable next frame because free_mask comes from slot_q.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].active) begin
        if (hit_clear[i]) begin
          slot_d[i].active = 1'b0;
        end else if (must_retire(slot_q[i])) begin
          slot_d[i].active = 1'b0;
        end else begin
          slot_d[i].x = slot_q[i].dir ? (slot_q[i].x + step_of(slot_q[i].kind))
                                      : (slot_q[i].x - step_of(slot_q[i].kind));
          if (slot_q[i].kind == BULLET) begin
            slot_d[i].range = slot_q[i].range - 6'd1;
          end
        end
      end else if (accept && (alloc_idx == IDX_W'(i))) begin
        slot_d[i].active = 1'b1;
        slot_d[i].kind   = miss_req ? MISSILE : BULLET;
        slot_d[i].dir    = facing;
        slot_d[i].x      = spawn_x;
        slot_d[i].y      = player_y;
        slot_d[i].range  = BULLET_RANGE;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      key_prev     <= 8'd0;
      cooldown     <= 4'd0;
      ammo         <= MISSILE_MAX;
      shot_fired   <= 1'b0;
      shot_dropped <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      key_prev     <= keycode;
      shot_fired   <= accept;
      shot_dropped <= any_req && !accept;

      if (accept) begin
        cooldown <= COOLDOWN;
      end else if (cooldown != 4'd0) begin
        cooldown <= cooldown - 4'd1;
      end

      // A pickup and a missile launch in the same frame cancel out.
      if (accept && miss_req && !ammo_add) begin
        ammo <= ammo - 5'd1;
      end else if (ammo_add && !(accept && miss_req) && (ammo < MISSILE_MAX)) begin
        ammo <= ammo + 5'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign slot_active[g]      = slot_q[g].active;
    assign slot_kind[g]        = slot_q[g].kind;
    assign slot_x[10*g +: 10]  = slot_q[g].x;
    assign slot_y[10*g +: 10]  = slot_q[g].y;
  end

endmodule

// File: tb/tb_projectile_scheduler.sv
module tb_projectile_scheduler;

  localparam int NS = 4;

  logic          frame_clk;
  logic          Reset;
  logic [7:0]    keycode;
  logic [9:0]    player_x;
  logic [9:0]    player_y;
  logic          facing;
  logic          ammo_add;
  logic [NS-1:0] hit_clear;
  logic [NS-1:0] slot_active;
  logic [NS-1:0] slot_kind;
  logic [10*NS-1:0] slot_x;
  logic [10*NS-1:0] slot_y;
  logic [4:0]    ammo;
  logic          shot_fired;
  logic          shot_dropped;

  int n_checks = 0;
  int n_pass   = 0;

  projectile_scheduler dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .player_x     (player_x),
    .player_y     (player_y),
    .facing       (facing),
    .ammo_add     (ammo_add),
    .hit_clear    (hit_clear),
    .slot_active  (slot_active),
    .slot_kind    (slot_kind),
    .slot_x       (slot_x),
    .slot_y       (slot_y),
    .ammo         (ammo),
    .shot_fired   (shot_fired),
    .shot_dropped (shot_dropped)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_act [NS];
  int m_kind[NS];
  int m_dir [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_rng [NS];
  int m_prev, m_cd, m_ammo, m_fired, m_dropped;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NS; i++) begin
        m_act[i] = 0; m_kind[i] = 0; m_dir[i] = 0;
        m_x[i] = 0; m_y[i] = 0; m_rng[i] = 0;
      end
      m_prev = 0; m_cd = 0; m_ammo = 10; m_fired = 0; m_dropped = 0;
    end else begin
      int  fire, miss, idx, ok, st, kc;
      kc   = int'(keycode);
      fire = (kc == 13 && m_prev != 13) ? 1 : 0;
      miss = (kc == 14 && m_prev != 14) ? 1 : 0;
      idx  = -1;
      for (int i = 0; i < NS; i++) if (m_act[i] == 0 && idx < 0) idx = i;
      ok = ((fire || miss) && m_cd == 0 && idx >= 0 && (fire || m_ammo > 0)) ? 1 : 0;
      for (int i = 0; i < NS; i++) begin
        if (m_act[i] != 0) begin
          st = m_kind[i] ? 5 : 8;
          if (hit_clear[i]) m_act[i] = 0;
          else if ((m_dir[i] && m_x[i] + st > 639) || (!m_dir[i] && m_x[i] - st < 0) ||
                   (m_kind[i] == 0 && m_rng[i] == 1)) m_act[i] = 0;
          else begin
            m_x[i] = m_dir[i] ? m_x[i] + st : m_x[i] - st;
            if (m_kind[i] == 0) m_rng[i] = m_rng[i] - 1;
          end
        end
      end
      if (ok) begin
        m_act[idx]  = 1;
        m_kind[idx] = miss;
        m_dir[idx]  = int'(facing);
        m_x[idx]    = facing ? ((int'(player_x) + 8 > 639) ? 639 : int'(player_x) + 8)
                             : ((int'(player_x) - 8 < 0) ? 0 : int'(player_x) - 8);
        m_y[idx]    = int'(player_y);
        m_rng[idx]  = 20;
      end
      m_cd = ok ? 6 : ((m_cd > 0) ? m_cd - 1 : 0);
      if (ok && miss && !ammo_add) m_ammo = m_ammo - 1;
      else if (ammo_add && !(ok && miss) && m_ammo < 10) m_ammo = m_ammo + 1;
      m_prev    = kc;
      m_fired   = ok;
      m_dropped = ((fire || miss) && !ok) ? 1 : 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge frame_clk) begin
    if (!Reset) begin
      for (int i = 0; i < NS; i++) begin
        chk($sformatf("active[%0d]", i), int'(slot_active[i]), m_act[i]);
        if (m_act[i] != 0) begin
          chk($sformatf("kind[%0d]", i), int'(slot_kind[i]), m_kind[i]);
          chk($sformatf("x[%0d]", i), int'(slot_x[10*i +: 10]), m_x[i]);
          chk($sformatf("y[%0d]", i), int'(slot_y[10*i +: 10]), m_y[i]);
        end
      end
      chk("ammo", int'(ammo), m_ammo);
      chk("shot_fired", int'(shot_fired), m_fired);
      chk("shot_dropped", int'(shot_dropped), m_dropped);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge frame_clk);
  endtask

  task automatic idle(input int n);
    keycode = 8'd0;
    repeat (n) tick();
  endtask

  task automatic press(input logic [7:0] kc);
    keycode = kc;
    tick();
    keycode = 8'd0;
  endtask

  task automatic clear_all();
    hit_clear = '1;
    keycode   = 8'd0;
    tick();
    hit_clear = '0;
  endtask

  initial begin
    int fired_cnt, life;
    Reset = 1'b1; keycode = 8'd0; player_x = 10'd320; player_y = 10'd200;
    facing = 1'b1; ammo_add = 1'b0; hit_clear = '0;
    repeat (2) tick();
    Reset = 1'b0;
    chk("reset_active", int'(slot_active), 0);
    chk("reset_ammo", int'(ammo), 10);
    chk("reset_fired", int'(shot_fired), 0);

    // held fire key: one shot, spawn at 328, +8 per frame
    keycode = 8'd13;
    tick();
    chk("s1_active0", int'(slot_active[0]), 1);
    chk("s1_spawn_x", int'(slot_x[9:0]), 328);
    chk("s1_model_x", m_x[0], 328);
    fired_cnt = int'(shot_fired);
    tick();
    chk("s1_move_x", int'(slot_x[9:0]), 336);
    for (int f = 0; f < 8; f++) begin
      fired_cnt += int'(shot_fired);
      tick();
    end
    fired_cnt += int'(shot_fired);
    chk("s1_fired_once", fired_cnt, 1);
    clear_all();
    idle(7);

    // cooldown: frame0 ok, frame3 dropped, frame7 ok -> slot1
    press(8'd13);
    idle(2);
    press(8'd13);
    chk("s2_cooldown_drop", int'(shot_dropped), 1);
    idle(3);
    press(8'd13);
    chk("s2_fired", int'(shot_fired), 1);
    chk("s2_active", int'(slot_active), 3);
    clear_all();
    idle(7);

    // fill pool with missiles, 5th press rejected
    repeat (4) begin
      press(8'd14);
      idle(6);
    end
    chk("s3_full", int'(slot_active), 15);
    chk("s3_ammo", int'(ammo), 6);
    press(8'd14);
    chk("s3_pool_drop", int'(shot_dropped), 1);
    clear_all();
    idle(7);

    // bullet range expiry
    player_x = 10'd100;
    press(8'd13);
    chk("s4_spawn_x", int'(slot_x[9:0]), 108);
    life = 1;
    for (int f = 0; f < 40; f++) begin
      tick();
      if (slot_active[0]) life++;
      else break;
    end
    chk("s4_life", life, 20);
    idle(7);

    // edge clamps and retire on the following frame
    facing = 1'b0; player_x = 10'd4;
    press(8'd13);
    chk("s5_left_x", int'(slot_x[9:0]), 0);
    tick();
    chk("s5_left_retire", int'(slot_active), 0);
    idle(6);
    facing = 1'b1; player_x = 10'd630;
    press(8'd14);
    chk("s5_right_x", int'(slot_x[9:0]), 638);
    chk("s5_kind", int'(slot_kind[0]), 1);
    tick();
    chk("s5_right_retire", int'(slot_active), 0);
    chk("s5_ammo", int'(ammo), 5);

    // burn ammo down to 1
    repeat (4) begin
      idle(7);
      press(8'd14);
    end
    chk("s6_ammo1", int'(ammo), 1);
    idle(7);
    player_x = 10'd320;
    ammo_add = 1'b1;
    press(8'd14);
    ammo_add = 1'b0;
    chk("s6_cancel_ammo", int'(ammo), 1);
    chk("s6_cancel_fired", int'(shot_fired), 1);
    idle(6);
    hit_clear = 4'b0001;
    press(8'd13);
    hit_clear = '0;
    chk("s6_hit_alloc", int'(slot_active), 2);
    chk("s6_slot1_x", int'(slot_x[19:10]), 328);
    idle(7);
    press(8'd14);
    chk("s6_ammo0", int'(ammo), 0);
    idle(7);
    press(8'd14);
    chk("s6_no_ammo_drop", int'(shot_dropped), 1);

    // ammo_add at full capacity is ignored
    #2 Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ammo_add = 1'b1;
    tick();
    ammo_add = 1'b0;
    chk("s7_ammo_sat", int'(ammo), 10);

    // randomized traffic
    for (int f = 0; f < 3000; f++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 3))
          0: keycode = 8'd0;
          1: keycode = 8'd13;
          2: keycode = 8'd14;
          default: keycode = 8'd7;
        endcase
      end
      if ($urandom_range(0, 15) == 0) player_x = 10'($urandom_range(0, 1023));
      player_y  = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 19) == 0) facing = ~facing;
      ammo_add  = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NS; i++) hit_clear[i] = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
